// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The checksum trailer (LOADER_CHECKSUM_EN) uses the CHK state.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // Byte-accepting states; s_ready is derived directly from the state register.
  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler, shared by header, data and trailer.
// word_valid_o/word_o are combinational and valid in the same cycle as the 4th byte.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  // The earlier three bytes sit in shift_q, oldest in the low byte.
  assign word_valid_o = byte_valid_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/instr_mem_loader.sv
// Streamed program loader: header N, N LE words written to instruction RAM, core released.
// Define LOADER_CHECKSUM_EN to require a 4-byte sum trailer (CHK state) before release.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [32:0]       CAP   = 33'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    wl_q, wl_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                asm_clr;
  logic                byte_acc;
  logic                word_valid;
  logic [31:0]         word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]         sum_q, sum_d;
`endif

  assign byte_acc = s_valid_i && s_ready_o;

  loader_word_asm u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (asm_clr),
    .byte_valid_i (byte_acc),
    .byte_i       (s_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_clr = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = HDR;
          wl_d    = '0;
          asm_clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      HDR: begin
        if (word_valid) begin
          if ((word == 32'd0) || ({1'b0, word} > CAP)) begin
            state_d = ERR;
          end else begin
            n_d     = word[CNT_W-1:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = BASE + wl_q[ADDR_W-1:0];
          wdata_d = word;
          wl_d    = wl_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
          if (wl_d == n_q) state_d = CHK;
`else
          if (wl_d == n_q) state_d = DONE;
`endif
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (word_valid) state_d = (word == sum_q) ? DONE : ERR;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Release lags DONE entry by a cycle so the final RAM write lands first.
    done_d = (state_q == DONE) && (state_d == DONE);
  end

  assign s_ready_o      = accepts_bytes(state_q);
  assign busy_o         = accepts_bytes(state_q);
  assign err_o          = (state_q == ERR);
  assign done_o         = done_q;
  assign core_rst_n_o   = done_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: image loads, stream gaps, header errors, reset, start handling.
module tb_instr_mem_loader;

  localparam int ADDR_W = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [7:0]        s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_rst_n_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   words_loaded_o;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  bit                ready_drop;

  localparam logic [31:0] IMG [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113};

  instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .core_rst_n_o   (core_rst_n_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_wdata_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    s_valid_i = 1'b0;
    repeat (g) begin
      tick();
      if (s_ready_o !== 1'b1) ready_drop = 1'b1;
    end
    s_data_i  = b;
    s_valid_i = 1'b1;
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic load_img(input int n, input bit gaps);
    logic [31:0] sum;
    sum = '0;
    send_word(32'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      send_word(IMG[i], gaps);
      sum = sum + IMG[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(sum, gaps);
`endif
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_count"}, 64'(wr_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 64'(wr_addr[i]), 64'(i));
      check({tag, "_data"}, 64'(wr_data[i]), 64'(IMG[i]));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"},      64'(mem_we_o),       64'(0));
    check({tag, "_addr"},    64'(mem_addr_o),     64'(0));
    check({tag, "_wdata"},   64'(mem_wdata_o),    64'(0));
    check({tag, "_corerst"}, 64'(core_rst_n_o),   64'(0));
    check({tag, "_busy"},    64'(busy_o),         64'(0));
    check({tag, "_done"},    64'(done_o),         64'(0));
    check({tag, "_err"},     64'(err_o),          64'(0));
    check({tag, "_wl"},      64'(words_loaded_o), 64'(0));
    check({tag, "_ready"},   64'(s_ready_o),      64'(0));
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; ready_drop = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    check_idle("reset");

    // 1: back-to-back load of three words
    pulse_start();
    check("t1_ready_hdr", 64'(s_ready_o), 64'(1));
    load_img(3, 1'b0);
`ifndef LOADER_CHECKSUM_EN
    check("t1_last_we",      64'(mem_we_o),     64'(1));
    check("t1_held_at_we",   64'(core_rst_n_o), 64'(0));
`endif
    tick();
    check("t1_core_rst_n", 64'(core_rst_n_o),   64'(1));
    check("t1_done",       64'(done_o),         64'(1));
    check("t1_wl",         64'(words_loaded_o), 64'(3));
    check("t1_ready_done", 64'(s_ready_o),      64'(0));
    check_writes("t1", 3);

    // 2: same image with stream gaps
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("t2_core_held", 64'(core_rst_n_o), 64'(0));
    load_img(3, 1'b1);
    tick();
    check("t2_done",        64'(done_o),     64'(1));
    check("t2_ready_steady", 64'(ready_drop), 64'(0));
    check_writes("t2", 3);

    // 5: start during DATA is ignored, start in DONE restarts
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'd3, 1'b0);
    send_word(IMG[0], 1'b0);
    pulse_start();
    check("t5_ign_busy", 64'(busy_o),         64'(1));
    check("t5_ign_wl",   64'(words_loaded_o), 64'(1));
    send_word(IMG[1], 1'b0);
    send_word(IMG[2], 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_word(IMG[0] + IMG[1] + IMG[2], 1'b0);
`endif
    tick();
    check("t5_done", 64'(done_o), 64'(1));
    check_writes("t5", 3);
    pulse_start();
    check("t5_restart_corerst", 64'(core_rst_n_o),   64'(0));
    check("t5_restart_wl",      64'(words_loaded_o), 64'(0));
    check("t5_restart_done",    64'(done_o),         64'(0));
    check("t5_restart_busy",    64'(busy_o),         64'(1));

    // 3: header N=0, then N=2**ADDR_W+1
    wr_addr.delete(); wr_data.delete();
    send_word(32'd0, 1'b0);
    check("t3_zero_err",   64'(err_o),        64'(1));
    check("t3_zero_core",  64'(core_rst_n_o), 64'(0));
    check("t3_zero_ready", 64'(s_ready_o),    64'(0));
    pulse_start();
    check("t3_err_clear", 64'(err_o), 64'(0));
    send_word(32'h0000_0401, 1'b0);
    check("t3_big_err",  64'(err_o),        64'(1));
    check("t3_big_core", 64'(core_rst_n_o), 64'(0));
    check("t3_no_we",    64'(wr_addr.size()), 64'(0));

    // 4: reset in the middle of DATA, then a fresh load
    pulse_start();
    send_word(32'd3, 1'b0);
    send_word(IMG[0], 1'b0);
    send_word(IMG[1], 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle("t4_rst");
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    load_img(3, 1'b0);
    tick();
    check("t4_done", 64'(done_o), 64'(1));
    check_writes("t4", 3);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum trailer match and mismatch
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    tick();
    check("t6_ok_done", 64'(done_o),       64'(1));
    check("t6_ok_core", 64'(core_rst_n_o), 64'(1));
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd4, 1'b0);
    tick();
    check("t6_bad_err",  64'(err_o),        64'(1));
    check("t6_bad_core", 64'(core_rst_n_o), 64'(0));
    check("t6_bad_done", 64'(done_o),       64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
